// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces two coin sensors, qualifies coins and queues them.
// Queued credits go to a downstream vending FSM as single-cycle pulses, with
// at least one idle cycle between pulses and none while the FSM raises hold.
`timescale 1ns/1ps
module coin_acceptor #(
  parameter int unsigned DEBOUNCE = 4  // stable cycles to qualify / re-arm (1..255)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_5,
  input  logic       raw_10,
  input  logic       hold,
  output logic       coin_5,
  output logic       coin_10,
  output logic       reject,
  output logic [2:0] fifo_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // armed, waiting for a sensor
    QUAL     = 2'd1,  // one sensor high, counting stable cycles
    PUSH     = 2'd2,  // qualified, enqueue (or reject if full)
    WAIT_LOW = 2'd3   // waiting for both sensors to stay low before re-arming
  } state_e;

  localparam logic [8:0] DEB   = 9'(DEBOUNCE);
  localparam int unsigned DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  logic [1:0] sync5_q;
  logic [1:0] sync10_q;
  logic       s5;
  logic       s10;

  // Two-flop synchronisers bring the asynchronous sensors into the clk domain.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync5_q  <= '0;
      sync10_q <= '0;
    end else begin
      sync5_q  <= {sync5_q[0], raw_5};
      sync10_q <= {sync10_q[0], raw_10};
    end
  end

  assign s5  = sync5_q[1];
  assign s10 = sync10_q[1];

  // ---------------------------------------------------------------------------
  // Qualifier FSM
  // ---------------------------------------------------------------------------
  state_e     state_q;
  logic [7:0] cnt_q;
  logic       type_q;     // 0 = Rs.5, 1 = Rs.10
  logic       reject_q;

  logic [8:0] cnt_inc;    // one bit wider so DEBOUNCE=255 compares cleanly
  logic       line_hi;    // the latched coin line
  logic       other_hi;   // the opposite coin line
  logic       full;

  // Select the latched and opposite lines for the coin being qualified.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    line_hi  = 1'b0;
    other_hi = 1'b0;
    if (type_q) begin
      line_hi  = s10;
      other_hi = s5;
    end else begin
      line_hi  = s5;
      other_hi = s10;
    end
  end

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  // Qualifier state machine with a registered reject pulse.
  // Reset parks it in WAIT_LOW so a sensor held high across reset is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_LOW;
      cnt_q    <= '0;
      type_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s5 && s10) begin
            // Two coins at once cannot be told apart: return them.
            reject_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= WAIT_LOW;
          end else if (s5 || s10) begin
            type_q  <= s10;
            cnt_q   <= 8'd1;
            // With a one-cycle debounce the first high sample already qualifies.
            state_q <= (DEB <= 9'd1) ? PUSH : QUAL;
          end
        end

        QUAL: begin
          if (line_hi && other_hi) begin
            reject_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= WAIT_LOW;
          end else if (!line_hi) begin
            // Too short to be a coin: treat as a glitch, no credit or reject.
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_inc[7:0];
            if (cnt_inc >= DEB) begin
              state_q <= PUSH;
            end
          end
        end

        PUSH: begin
          // Full check uses the pre-pop occupancy, so a concurrent pop does
          // not make room for this coin.
          reject_q <= full;
          cnt_q    <= '0;
          state_q  <= WAIT_LOW;
        end

        WAIT_LOW: begin
          if (s5 || s10) begin
            cnt_q <= '0;
          end else if (cnt_inc >= DEB) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_inc[7:0];
          end
        end

        default: begin
          cnt_q   <= '0;
          state_q <= WAIT_LOW;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Coin FIFO and output pulse generator
  // ---------------------------------------------------------------------------
  logic       fifo_q [DEPTH];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic [2:0] count_d;
  logic       coin_5_q;
  logic       coin_10_q;
  logic       empty;
  logic       push;
  logic       pop;
  logic       head;

  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);
  assign push  = (state_q == PUSH) && !full;
  // A pulse currently on the outputs blocks the next pop, forcing a gap cycle.
  assign pop   = !empty && !hold && !(coin_5_q || coin_10_q);
  assign head  = fifo_q[rd_ptr_q];

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage: written only by push, read through the head pointer.
  // NOTE: the storage array is not reset; the pointers and count define which
  // entries are valid, so clearing them is enough and keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= type_q;
    end
  end

  // Pointers, occupancy and the registered coin pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      coin_5_q  <= 1'b0;
      coin_10_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q   <= count_d;
      coin_5_q  <= pop && !head;
      coin_10_q <= pop && head;
    end
  end

  assign coin_5     = coin_5_q;
  assign coin_10    = coin_10_q;
  assign reject     = reject_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: scenario tasks drive coins; expected credits are queued
// as stimulus is applied and popped by a monitor as pulses appear.
`timescale 1ns/1ps
module tb_coin_acceptor;

  localparam int D = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       raw_5  = 1'b0;
  logic       raw_10 = 1'b0;
  logic       hold   = 1'b0;
  logic       coin_5;
  logic       coin_10;
  logic       reject;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  int rej_seen = 0;
  int pulse_seen = 0;
  bit exp_q[$];           // expected coin types in credit order (1 = Rs.10)
  logic prev_pulse = 1'b0;

  coin_acceptor #(.DEBOUNCE(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_5      (raw_5),
    .raw_10     (raw_10),
    .hold       (hold),
    .coin_5     (coin_5),
    .coin_10    (coin_10),
    .reject     (reject),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: samples on the falling edge, pops one expected coin
  // per pulse and checks type, exclusivity and the mandatory gap cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_pulse = 1'b0;
    end else begin
      if (reject) rej_seen++;
      if (coin_5 || coin_10) begin
        pulse_seen++;
        n_cmp++;
        if (coin_5 && coin_10) begin
          n_err++;
          $display("FAIL both_pulses: coin_5=%0b coin_10=%0b, expected only one high", coin_5, coin_10);
        end
        n_cmp++;
        if (prev_pulse) begin
          n_err++;
          $display("FAIL pulse_gap: pulse in consecutive cycles at %0t, expected a low cycle between", $time);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: coin_5=%0b coin_10=%0b at %0t, expected no pulse", coin_5, coin_10, $time);
        end else begin
          automatic bit e = exp_q.pop_front();
          if (coin_10 !== e) begin
            n_err++;
            $display("FAIL coin_type: got coin_10=%0b, expected coin_10=%0b", coin_10, e);
          end
        end
      end
      prev_pulse = coin_5 || coin_10;
    end
  end

  // Applies one coin starting now (just after a falling edge), holds the
  // sensor for hi_cyc cycles and reports when the matching pulse appeared.
  task automatic measure_coin(input bit is10, input int hi_cyc, output int lat,
                              output logic [2:0] fc_push, output logic [2:0] fc_pop);
    exp_q.push_back(is10);
    lat     = -1;
    fc_push = 'x;
    fc_pop  = 'x;
    if (is10) raw_10 = 1'b1; else raw_5 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == hi_cyc) begin
        raw_5  = 1'b0;
        raw_10 = 1'b0;
      end
      if (n == D + 3) fc_push = fifo_count;
      if (n == D + 4) fc_pop = fifo_count;
      if (lat < 0 && (is10 ? coin_10 : coin_5)) lat = n;
    end
  endtask

  // Clean coin of the given type while the sensors are otherwise quiet.
  task automatic clean_coin(input bit is10, input int hi_cyc, input int lo_cyc);
    if (is10) raw_10 = 1'b1; else raw_5 = 1'b1;
    repeat (hi_cyc) @(negedge clk);
    raw_5  = 1'b0;
    raw_10 = 1'b0;
    repeat (lo_cyc) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({coin_5, coin_10, reject, fifo_count} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 000000", {coin_5, coin_10, reject, fifo_count});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if ({coin_5, coin_10, reject, fifo_count} !== 6'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b, expected 000000", {coin_5, coin_10, reject, fifo_count});
    end
  endtask

  task automatic test_single_coin();
    int lat;
    logic [2:0] fp, fo;
    int r0 = rej_seen;
    measure_coin(1'b0, 10, lat, fp, fo);
    n_cmp++;
    if (lat !== D + 4) begin
      n_err++;
      $display("FAIL single_latency: got %0d, expected %0d", lat, D + 4);
    end
    n_cmp++;
    if (fp !== 3'd1) begin
      n_err++;
      $display("FAIL single_count_push: got %0d, expected 1", fp);
    end
    n_cmp++;
    if (fo !== 3'd0) begin
      n_err++;
      $display("FAIL single_count_pop: got %0d, expected 0", fo);
    end
    n_cmp++;
    if (rej_seen - r0 !== 0) begin
      n_err++;
      $display("FAIL single_reject: got %0d, expected 0", rej_seen - r0);
    end
  endtask

  // A two-cycle Rs.10 glitch must vanish and leave the qualifier armed, so a
  // Rs.5 coin right behind it still sees the minimum latency.
  task automatic test_glitch();
    int lat;
    logic [2:0] fp, fo;
    int r0 = rej_seen;
    int p0 = pulse_seen;
    raw_10 = 1'b1;
    repeat (2) @(negedge clk);
    raw_10 = 1'b0;
    @(negedge clk);
    measure_coin(1'b0, 10, lat, fp, fo);
    n_cmp++;
    if (lat !== D + 4) begin
      n_err++;
      $display("FAIL glitch_rearm_latency: got %0d, expected %0d", lat, D + 4);
    end
    n_cmp++;
    if (rej_seen - r0 !== 0) begin
      n_err++;
      $display("FAIL glitch_reject: got %0d, expected 0", rej_seen - r0);
    end
    n_cmp++;
    if (pulse_seen - p0 !== 1) begin
      n_err++;
      $display("FAIL glitch_pulses: got %0d, expected 1", pulse_seen - p0);
    end
  endtask

  task automatic test_both_lines();
    int r0 = rej_seen;
    int p0 = pulse_seen;
    raw_5  = 1'b1;
    raw_10 = 1'b1;
    repeat (6) @(negedge clk);
    raw_5  = 1'b0;
    raw_10 = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (rej_seen - r0 !== 1) begin
      n_err++;
      $display("FAIL both_reject: got %0d, expected 1", rej_seen - r0);
    end
    n_cmp++;
    if (pulse_seen - p0 !== 0) begin
      n_err++;
      $display("FAIL both_pulses_count: got %0d, expected 0", pulse_seen - p0);
    end
    n_cmp++;
    if (fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL both_fifo_count: got %0d, expected 0", fifo_count);
    end
  endtask

  task automatic test_hold_full();
    int r0 = rej_seen;
    int p0 = pulse_seen;
    int npulse = 0;
    int last_n = 0;
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back(1'b1);
      clean_coin(1'b1, 8, 8);
    end
    n_cmp++;
    if (fifo_count !== 3'd4) begin
      n_err++;
      $display("FAIL full_count: got %0d, expected 4", fifo_count);
    end
    n_cmp++;
    if (rej_seen - r0 !== 1) begin
      n_err++;
      $display("FAIL full_reject: got %0d, expected 1", rej_seen - r0);
    end
    n_cmp++;
    if (pulse_seen - p0 !== 0) begin
      n_err++;
      $display("FAIL hold_stall: got %0d pulses, expected 0", pulse_seen - p0);
    end
    hold = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (coin_10) begin
        if (npulse > 0) begin
          n_cmp++;
          if (n - last_n !== 2) begin
            n_err++;
            $display("FAIL drain_spacing: got %0d cycles, expected 2", n - last_n);
          end
        end
        last_n = n;
        npulse++;
      end
    end
    n_cmp++;
    if (npulse !== 4) begin
      n_err++;
      $display("FAIL drain_pulses: got %0d, expected 4", npulse);
    end
    n_cmp++;
    if (fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL drain_count: got %0d, expected 0", fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    bit seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int r0 = rej_seen;
    int p0 = pulse_seen;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(seq[k]);
      clean_coin(seq[k], 6, 6);
    end
    repeat (15) @(negedge clk);
    n_cmp++;
    if (pulse_seen - p0 !== 4) begin
      n_err++;
      $display("FAIL b2b_pulses: got %0d, expected 4", pulse_seen - p0);
    end
    n_cmp++;
    if (rej_seen - r0 !== 0) begin
      n_err++;
      $display("FAIL b2b_reject: got %0d, expected 0", rej_seen - r0);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_outstanding: got %0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_held();
    int lat;
    logic [2:0] fp, fo;
    int p0 = pulse_seen;
    raw_5 = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (pulse_seen - p0 !== 0 || fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL held_across_reset: got %0d pulses count=%0d, expected 0 pulses count=0",
               pulse_seen - p0, fifo_count);
    end
    raw_5 = 1'b0;
    repeat (6) @(negedge clk);
    measure_coin(1'b0, 10, lat, fp, fo);
    n_cmp++;
    if (lat !== D + 4) begin
      n_err++;
      $display("FAIL held_new_coin_latency: got %0d, expected %0d", lat, D + 4);
    end
  endtask

  // Three queued coins plus one mid-qualification are all lost to reset.
  task automatic test_reset_flush();
    int p0;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(1'b1);
      clean_coin(1'b1, 8, 8);
    end
    n_cmp++;
    if (fifo_count !== 3'd3) begin
      n_err++;
      $display("FAIL flush_precount: got %0d, expected 3", fifo_count);
    end
    raw_5 = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    n_cmp++;
    if ({coin_5, coin_10, reject, fifo_count} !== 6'b0) begin
      n_err++;
      $display("FAIL flush_immediate: got %b, expected 000000", {coin_5, coin_10, reject, fifo_count});
    end
    p0 = pulse_seen;
    raw_5 = 1'b0;
    hold  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (pulse_seen - p0 !== 0) begin
      n_err++;
      $display("FAIL flush_pulses: got %0d, expected 0", pulse_seen - p0);
    end
    n_cmp++;
    if (fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL flush_count: got %0d, expected 0", fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_coin();
    test_glitch();
    test_both_lines();
    test_hold_full();
    test_back_to_back();
    test_reset_held();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4, meaning consecutive stable cycles needed to qualify or re-arm a coin line (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port raw_5  input  1  unsynchronised Rs.5 coin sensor, high while a coin passes.
REQ-005 SHALL have port raw_10  input  1  unsynchronised Rs.10 coin sensor, high while a coin passes.
REQ-006 SHALL have port hold  input  1  downstream vending FSM busy; no coin pulse is issued while high.
REQ-007 SHALL have port coin_5  output  1  registered single-cycle pulse, one Rs.5 credit to vending machine.
REQ-008 SHALL have port coin_10  output  1  registered single-cycle pulse, one Rs.10 credit to vending machine.
REQ-009 SHALL have port reject  output  1  registered single-cycle pulse, coin returned to customer.
REQ-010 SHALL have port fifo_count  output  3  number of queued qualified coins, 0..4.

Function
REQ-011 SHALL pass raw_5 and raw_10 each through a two-flop synchroniser (s5, s10) before any other use.
REQ-012 SHALL implement qualifier FSM with states IDLE, QUAL, PUSH, WAIT_LOW; 8-bit stability counter.
REQ-013 IDLE: exactly one of s5/s10 high -> QUAL, counter=1, latch coin type; both high -> WAIT_LOW with reject pulse; neither -> stay.
REQ-014 QUAL: latched line high, other low -> counter+1; counter reaching DEBOUNCE -> PUSH.
REQ-015 QUAL: latched line drops before DEBOUNCE -> IDLE silently (glitch, no reject, no credit).
REQ-016 QUAL: other line rises (both high) -> WAIT_LOW with reject pulse, nothing queued.
REQ-017 PUSH: one cycle; write coin type into FIFO if fifo_count<4, else reject pulse and drop; then WAIT_LOW, counter=0.
REQ-018 WAIT_LOW: both lines low -> counter+1, any line high -> counter=0; counter reaching DEBOUNCE -> IDLE (re-armed).
REQ-019 SHALL hold a 4-entry FIFO of 1-bit coin type (0=Rs.5, 1=Rs.10) with 2-bit wrapping pointers; fifo_count reflects entries after each edge.
REQ-020 SHALL issue a pulse when FIFO non-empty, hold low, and no pulse in previous cycle: pop head, assert coin_5 or coin_10 for exactly one cycle next cycle.
REQ-021 SHALL guarantee at least one low cycle between successive coin pulses; coin_5 and coin_10 never high together.
REQ-022 Simultaneous push and pop in the same cycle SHALL both take effect; fifo_count unchanged; full-check uses pre-pop count (push while full with pop still rejects).
REQ-023 hold rising while FIFO non-empty SHALL stall output only; qualifier keeps running and queueing.
REQ-024 Latency, empty FIFO, hold low, clean coin: coin pulse high in cycle DEBOUNCE+4 after first edge sampling raw high.
REQ-025 reject SHALL be at most one cycle per coin event; reject and coin pulse may coincide.

Reset
REQ-026 reset high SHALL immediately force coin_5=0, coin_10=0, reject=0, fifo_count=0, synchronisers 0, counter 0, FIFO pointers 0.
REQ-027 Reset SHALL put FSM in WAIT_LOW, so a sensor held high across reset release is never credited.
REQ-028 Reset mid-QUAL or with queued coins SHALL discard them without any pulse.

Verification
REQ-029 DEBOUNCE=4, raw_5 high 10 cycles, hold low -> single coin_5 pulse in cycle 8, fifo_count 1 then 0.
REQ-030 raw_10 high 2 cycles then low -> no coin_10, no reject, FSM back to IDLE.
REQ-031 raw_5 and raw_10 rise together -> one reject pulse, no coin pulses, fifo_count 0.
REQ-032 hold high, five clean Rs.10 coins -> fifo_count 4, fifth gives reject; release hold -> four coin_10 pulses spaced one gap cycle.
REQ-033 raw_5 held high through reset deassertion -> no coin_5 until raw_5 low >=4 cycles and a new coin qualifies.
REQ-034 Reset asserted with fifo_count 3 -> outputs and fifo_count 0 same cycle, no pulses after release.
